// File: rtl/fa32bit_sc.sv
// 32-bit carry-select adder: 8 blocks of 4-bit ripple adders. Each upper block
// precomputes both carry-in cases. The result is available combinationally and also as a registered copy.
module fa32bit_sc (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  output logic [31:0] SUM,
  output logic        Cout,
  output logic        V,
  output logic [31:0] SUM_R,
  output logic        COUT_R,
  output logic        V_R
);

  // Returns {carry_out, sum}
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    full_add = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  // Returns {carry_out, sum[3:0]}
  function automatic logic [4:0] ripple4(input logic [3:0] a, input logic [3:0] b,
                                         input logic c);
    logic [1:0] fa_r;
    logic       cy;
    cy = c;
    for (int i = 0; i < 4; i++) begin
      fa_r       = full_add(a[i], b[i], cy);
      ripple4[i] = fa_r[0];
      cy         = fa_r[1];
    end
    ripple4[4] = cy;
  endfunction

  logic [8:0]      blk_c;
  logic [7:0][4:0] blk_r;
  logic [31:0]     sum_c;
  logic            c31;

  assign blk_c[0] = Cin;
  assign blk_r[0] = ripple4(A[3:0], B[3:0], Cin);
  assign blk_c[1] = blk_r[0][4];

  genvar k;
  generate
    for (k = 1; k < 8; k++) begin : g_blk
      logic [4:0] r0, r1;
      assign r0         = ripple4(A[4*k+3:4*k], B[4*k+3:4*k], 1'b0);
      assign r1         = ripple4(A[4*k+3:4*k], B[4*k+3:4*k], 1'b1);
      assign blk_r[k]   = blk_c[k] ? r1 : r0;
      assign blk_c[k+1] = blk_r[k][4];
    end
    for (k = 0; k < 8; k++) begin : g_sum
      assign sum_c[4*k+3:4*k] = blk_r[k][3:0];
    end
  endgenerate

  // Since s = a^b^c, the carry into bit 31 is recovered from the sum bit itself
  assign c31  = A[31] ^ B[31] ^ sum_c[31];
  assign SUM  = sum_c;
  assign Cout = blk_c[8];
  assign V    = c31 ^ blk_c[8];

  // Output register stage
  logic [31:0] sum_q, sum_d;
  logic        cout_q, cout_d, v_q, v_d;

  assign sum_d  = sum_c;
  assign cout_d = blk_c[8];
  assign v_d    = c31 ^ blk_c[8];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      v_q    <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      v_q    <= v_d;
    end
  end

  assign SUM_R  = sum_q;
  assign COUT_R = cout_q;
  assign V_R    = v_q;

endmodule

// File: tb/tb_fa32bit_sc.sv
// Directed bench for fa32bit_sc: combinational vectors with hand-computed
// results, then reset and one-cycle latency of the registered copy.
module tb_fa32bit_sc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] A = '0, B = '0;
  logic        Cin = 1'b0;
  logic [31:0] SUM, SUM_R;
  logic        Cout, V, COUT_R, V_R;

  int vectors = 0;
  int miscompares = 0;

  fa32bit_sc dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin),
    .SUM(SUM), .Cout(Cout), .V(V),
    .SUM_R(SUM_R), .COUT_R(COUT_R), .V_R(V_R)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic comb(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic c, input logic [31:0] es, input logic ec, input logic ev);
    A = a; B = b; Cin = c;
    #10;
    check({tag, ".sum"}, SUM, es);
    check({tag, ".cout"}, {31'b0, Cout}, {31'b0, ec});
    check({tag, ".v"}, {31'b0, V}, {31'b0, ev});
  endtask

  initial begin
    comb("neg2",     32'hFFFFFFF6, 32'h00000008, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0);
    comb("fullprop", 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0);
    comb("posovf",   32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
    comb("negovf",   32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1);
    comb("sub",      32'h0000000A, ~32'h00000003, 1'b1, 32'h00000007, 1'b1, 1'b0);
    comb("allones",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    comb("zero",     32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0);
    comb("minm1",    32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1);
    comb("blkcross", 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0);
    comb("mixed",    32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0);

    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("rst.sum_r", SUM_R, 32'h0);
    check("rst.cout_r", {31'b0, COUT_R}, 32'h0);
    check("rst.v_r", {31'b0, V_R}, 32'h0);

    rst = 1'b0; A = 32'h12345678; B = 32'h11111111; Cin = 1'b0;
    @(posedge clk); #1;
    check("reg1.sum_r", SUM_R, 32'h23456789);
    check("reg1.cout_r", {31'b0, COUT_R}, 32'h0);
    check("reg1.v_r", {31'b0, V_R}, 32'h0);

    A = 32'h80000000; B = 32'h80000000; Cin = 1'b0;
    @(posedge clk); #1;
    check("reg2.sum_r", SUM_R, 32'h00000000);
    check("reg2.cout_r", {31'b0, COUT_R}, 32'h1);
    check("reg2.v_r", {31'b0, V_R}, 32'h1);

    A = 32'h12345678; B = 32'h11111111; Cin = 1'b0;
    @(posedge clk); #1;
    check("reg3.sum_r", SUM_R, 32'h23456789);

    rst = 1'b1;
    @(posedge clk); #1;
    check("rst2.sum_r", SUM_R, 32'h0);
    check("rst2.cout_r", {31'b0, COUT_R}, 32'h0);
    check("rst2.sum", SUM, 32'h23456789);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fa32bit_sc.md
Name: fa32bit_sc

Overview:
- 32-bit two's-complement adder with carry-select ("sc") structure, used in the Extended DLX ALU datapath.
- Main result (SUM, Cout, V) is purely combinational from A, B and Cin; SUM is valid in the same evaluation step.
- A registered copy of the result is provided for pipelined consumers; it uses the single clock and synchronous reset.

Parameters:
- none. Width is fixed at 32 bits.
- Block size is fixed at 4 bits, giving 8 blocks.

Ports:
- clk  input  1  rising-edge clock; used by the registered outputs only.
- rst  input  1  synchronous, active-high reset.
- A  input  32  operand A, unsigned or two's-complement.
- B  input  32  operand B.
- Cin  input  1  carry into bit 0.
- SUM  output  32  combinational A+B+Cin, modulo 2^32.
- Cout  output  1  combinational carry out of bit 31.
- V  output  1  combinational signed overflow.
- SUM_R  output  32  SUM registered on clk.
- COUT_R  output  1  Cout registered on clk.
- V_R  output  1  V registered on clk.

Behaviour:
- Arithmetic: {Cout,SUM} = A + B + Cin, computed as a 33-bit unsigned sum.
- V = (A[31]==B[31]) && (SUM[31]!=A[31]). Equivalently, carry into bit 31 XOR carry out of bit 31.
- Structure: 8 blocks of 4 bits each.
  - Block 0 is a 4-bit ripple adder driven directly by Cin.
  - Blocks 1..7 each contain two 4-bit ripple adders, one precomputed with carry-in 0 and one with carry-in 1.
  - The carry out of the previous block drives a 2:1 mux that selects that block's sum and carry.
  - Block-select carries chain from block 0 to block 7.
  - Carry into bit 31 must be available for V.
- Each 1-bit cell is a full adder: s = a^b^c, co = ab | ac | bc.
- Combinational outputs:
  - No clock dependency, no latency.
  - Unaffected by rst.
  - Must settle within one simulation delta chain; no explicit # delays in RTL.
  - Outputs are X only if an input is X/Z.
- Registered outputs:
  - On rising clk edge with rst=1: SUM_R=0, COUT_R=0, V_R=0.
  - On rising clk edge with rst=0: SUM_R<=SUM, COUT_R<=Cout, V_R<=V. Latency is one cycle.
  - Before the first clk edge, their value is undefined. A bench must reset before checking them.
- Reset mid-operation: only the registered outputs clear; combinational SUM/Cout/V continue tracking the inputs.
- No handshake. The block is fully pipelined and accepts new operands every cycle.
- Boundary cases:
  - Carry wraps modulo 2^32; the 33rd bit appears only on Cout.
  - Cin=1 with all-ones operands propagates through all 8 select stages.
- Subtraction is done by the caller: pass ~B with Cin=1.

Test Plan:
- A=FFFFFFF6, B=00000008, Cin=0 -> SUM=FFFFFFFE (signed -2), Cout=0, V=0. Result is valid 10 time units after the inputs are applied, with no clock.
- A=FFFFFFFF, B=00000000, Cin=1 -> SUM=00000000, Cout=1, V=0. This exercises full carry-select propagation.
- A=7FFFFFFF, B=00000001, Cin=0 -> SUM=80000000, Cout=0, V=1.
- A=80000000, B=80000000, Cin=0 -> SUM=00000000, Cout=1, V=1.
- A=0000000A, B=~00000003, Cin=1 -> SUM=00000007, Cout=1, V=0. This is the subtract usage.
- Hold rst=1 for 2 clk edges -> SUM_R=0, COUT_R=0, V_R=0. Then rst=0 and apply A=12345678, B=11111111, Cin=0 -> after the next edge SUM_R=23456789, COUT_R=0. Asserting rst again clears the registers on the next edge while SUM stays 23456789.
